// File: rtl/wts_wave_ram_pkg.sv
// Shared types and helpers for the wave-table sample memory.
package wts_wave_ram_pkg;

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_CLR,
        GNT_CPU,
        GNT_TONE
    } gnt_t;

    function automatic int unsigned ram_depth(input int unsigned addr_w, input int unsigned ch_w);
        return 32'd1 << (addr_w + ch_w);
    endfunction

endpackage

// File: rtl/wts_ram_sp.sv
// Single-port synchronous sample array: registered read, write-enable, no reset.
module wts_ram_sp #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= d;
            end else begin
                q <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/wts_wave_ram.sv
// Wave-table sample memory: clear sequencer plus CPU/tone arbiter over one
// single-port array, one access per clock.
module wts_wave_ram
    import wts_wave_ram_pkg::*;
#(
    parameter int unsigned       DATA_W    = 8,
    parameter int unsigned       ADDR_W    = 5,
    parameter int unsigned       CH_W      = 3,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_req,
    output logic              busy,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [CH_W-1:0]   cpu_ch,
    input  logic [ADDR_W-1:0] cpu_a,
    input  logic [DATA_W-1:0] cpu_d,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_q,
    output logic              cpu_q_valid,
    input  logic              tone_req,
    input  logic [CH_W-1:0]   tone_ch,
    input  logic [ADDR_W-1:0] tone_a,
    output logic              tone_ack,
    output logic [DATA_W-1:0] tone_q,
    output logic              tone_q_valid
);

    localparam int unsigned DEPTH = ram_depth(ADDR_W, CH_W);
    localparam int unsigned PA_W  = ADDR_W + CH_W;

    state_t            state, state_n;
    gnt_t              gnt;
    logic [PA_W-1:0]   cnt, cnt_n;
    logic              fair, fair_n;
    logic              cpu_pend, tone_pend;
    logic              cpu_v, tone_v;
    logic              ram_en, ram_we;
    logic [PA_W-1:0]   ram_addr;
    logic [DATA_W-1:0] ram_d, ram_q;

    // A request still high during its own ack cycle is already served.
    assign cpu_v  = cpu_req & ~cpu_ack;
    assign tone_v = tone_req & ~tone_ack;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        fair_n  = fair;
        gnt     = GNT_NONE;
        if (clear_req) begin
            state_n = ST_CLEAR;
            cnt_n   = '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    gnt   = GNT_CLR;
                    cnt_n = cnt + PA_W'(1);
                    if (cnt == '1) begin
                        state_n = ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (cpu_v && (!tone_v || !fair)) begin
                        gnt    = GNT_CPU;
                        fair_n = tone_req;
                    end else if (tone_v) begin
                        gnt    = GNT_TONE;
                        fair_n = 1'b0;
                    end
                end
                default: state_n = ST_CLEAR;
            endcase
        end
    end

    always_comb begin
        ram_en   = (gnt != GNT_NONE);
        ram_we   = (gnt == GNT_CLR) || ((gnt == GNT_CPU) && cpu_we);
        ram_addr = cnt;
        ram_d    = CLEAR_VAL;
        case (gnt)
            GNT_CPU: begin
                ram_addr = {cpu_ch, cpu_a};
                ram_d    = cpu_d;
            end
            GNT_TONE: ram_addr = {tone_ch, tone_a};
            default:  ram_addr = cnt;
        endcase
    end

    wts_ram_sp #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (PA_W)
    ) u_ram (
        .clk  (clk),
        .en   (ram_en),
        .we   (ram_we),
        .addr (ram_addr),
        .d    (ram_d),
        .q    (ram_q)
    );

    assign busy = (state == ST_CLEAR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_CLEAR;
            cnt          <= '0;
            fair         <= 1'b0;
            cpu_ack      <= 1'b0;
            tone_ack     <= 1'b0;
            cpu_pend     <= 1'b0;
            tone_pend    <= 1'b0;
            cpu_q        <= '0;
            tone_q       <= '0;
            cpu_q_valid  <= 1'b0;
            tone_q_valid <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            fair         <= fair_n;
            cpu_ack      <= (gnt == GNT_CPU);
            tone_ack     <= (gnt == GNT_TONE);
            cpu_pend     <= (gnt == GNT_CPU) && !cpu_we;
            tone_pend    <= (gnt == GNT_TONE);
            cpu_q_valid  <= cpu_pend;
            tone_q_valid <= tone_pend;
            if (cpu_pend) begin
                cpu_q <= ram_q;
            end
            if (tone_pend) begin
                tone_q <= ram_q;
            end
        end
    end

endmodule

// File: tb/tb_wts_wave_ram.sv
// Scenario-driven scoreboard bench for the wave-table sample memory.
module tb_wts_wave_ram;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear_req;
    logic       busy;
    logic       cpu_req;
    logic       cpu_we;
    logic [2:0] cpu_ch;
    logic [4:0] cpu_a;
    logic [7:0] cpu_d;
    logic       cpu_ack;
    logic [7:0] cpu_q;
    logic       cpu_q_valid;
    logic       tone_req;
    logic [2:0] tone_ch;
    logic [4:0] tone_a;
    logic       tone_ack;
    logic [7:0] tone_q;
    logic       tone_q_valid;

    int total = 0;
    int bad   = 0;

    logic [7:0] cpu_exp[$];
    logic [7:0] tone_exp[$];

    always #5 clk = ~clk;

    wts_wave_ram #(
        .DATA_W    (8),
        .ADDR_W    (5),
        .CH_W      (3),
        .CLEAR_VAL (8'h00)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .clear_req    (clear_req),
        .busy         (busy),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_ch       (cpu_ch),
        .cpu_a        (cpu_a),
        .cpu_d        (cpu_d),
        .cpu_ack      (cpu_ack),
        .cpu_q        (cpu_q),
        .cpu_q_valid  (cpu_q_valid),
        .tone_req     (tone_req),
        .tone_ch      (tone_ch),
        .tone_a       (tone_a),
        .tone_ack     (tone_ack),
        .tone_q       (tone_q),
        .tone_q_valid (tone_q_valid)
    );

    // Drives one CPU handshake; lat = cycles until ack, -1 on timeout.
    task automatic cpu_xfer(input logic we, input logic [2:0] ch, input logic [4:0] a,
                            input logic [7:0] d, output int lat);
        @(negedge clk);
        cpu_we = we; cpu_ch = ch; cpu_a = a; cpu_d = d; cpu_req = 1'b1;
        lat = -1;
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk); #1;
            if (cpu_ack) begin
                lat = i;
                break;
            end
        end
        cpu_req = 1'b0;
    endtask

    task automatic tone_xfer(input logic [2:0] ch, input logic [4:0] a, output int lat);
        @(negedge clk);
        tone_ch = ch; tone_a = a; tone_req = 1'b1;
        lat = -1;
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk); #1;
            if (tone_ack) begin
                lat = i;
                break;
            end
        end
        tone_req = 1'b0;
    endtask

    task automatic test_reset;
        int n;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_busy got=%b want=1", busy); end
        total++; if (cpu_ack !== 1'b0 || tone_ack !== 1'b0) begin bad++; $display("FAIL rst_ack got=%b%b want=00", cpu_ack, tone_ack); end
        total++; if (cpu_q_valid !== 1'b0 || tone_q_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b%b want=00", cpu_q_valid, tone_q_valid); end
        total++; if (cpu_q !== 8'h00) begin bad++; $display("FAIL rst_cpu_q got=%h want=00", cpu_q); end
        total++; if (tone_q !== 8'h00) begin bad++; $display("FAIL rst_tone_q got=%h want=00", tone_q); end
        @(negedge clk);
        reset = 1'b0;
        n = 1;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            if (busy) n++;
            else break;
        end
        total++; if (n != 256) begin bad++; $display("FAIL busy_len got=%0d want=256", n); end
    endtask

    task automatic test_clear_reads;
        int lat;
        cpu_exp.push_back(8'h00);
        cpu_xfer(1'b0, 3'd7, 5'd31, 8'h00, lat);
        total++; if (lat != 1) begin bad++; $display("FAIL rd7_31_lat got=%0d want=1", lat); end
        @(posedge clk); #1;
        total++; if (cpu_q_valid !== 1'b1 || cpu_q !== cpu_exp.pop_front()) begin bad++; $display("FAIL rd7_31 got=%b/%h want=1/00", cpu_q_valid, cpu_q); end
        cpu_exp.push_back(8'h00);
        cpu_xfer(1'b0, 3'd0, 5'd0, 8'h00, lat);
        total++; if (lat != 1) begin bad++; $display("FAIL rd0_0_lat got=%0d want=1", lat); end
        @(posedge clk); #1;
        total++; if (cpu_q_valid !== 1'b1 || cpu_q !== cpu_exp.pop_front()) begin bad++; $display("FAIL rd0_0 got=%b/%h want=1/00", cpu_q_valid, cpu_q); end
    endtask

    task automatic test_write_read;
        int lat;
        cpu_xfer(1'b1, 3'd2, 5'd5, 8'hA5, lat);
        total++; if (lat != 1) begin bad++; $display("FAIL wr_lat got=%0d want=1", lat); end
        @(posedge clk); #1;
        total++; if (cpu_q_valid !== 1'b0) begin bad++; $display("FAIL wr_novalid got=%b want=0", cpu_q_valid); end
        cpu_exp.push_back(8'hA5);
        cpu_xfer(1'b0, 3'd2, 5'd5, 8'h00, lat);
        total++; if (lat != 1) begin bad++; $display("FAIL rd_lat got=%0d want=1", lat); end
        @(posedge clk); #1;
        total++; if (cpu_q_valid !== 1'b1 || cpu_q !== cpu_exp.pop_front()) begin bad++; $display("FAIL rd_a5 got=%b/%h want=1/a5", cpu_q_valid, cpu_q); end
    endtask

    task automatic test_back_to_back;
        int last_tone, max_gap;
        logic want_cpu;
        last_tone = 0;
        max_gap = 0;
        @(negedge clk);
        cpu_we = 1'b0; cpu_ch = 3'd2; cpu_a = 5'd5; cpu_req = 1'b1;
        tone_ch = 3'd2; tone_a = 5'd5; tone_req = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            @(posedge clk); #1;
            if (c == 12) begin
                cpu_req = 1'b0;
                tone_req = 1'b0;
            end
            if (cpu_q_valid) begin
                total++;
                if (cpu_exp.size() == 0) begin bad++; $display("FAIL alt_cpu_q unexpected valid got=%h", cpu_q); end
                else if (cpu_q !== cpu_exp.pop_front()) begin bad++; $display("FAIL alt_cpu_q got=%h want=a5", cpu_q); end
            end
            if (tone_q_valid) begin
                total++;
                if (tone_exp.size() == 0) begin bad++; $display("FAIL alt_tone_q unexpected valid got=%h", tone_q); end
                else if (tone_q !== tone_exp.pop_front()) begin bad++; $display("FAIL alt_tone_q got=%h want=a5", tone_q); end
            end
            if (c <= 12) begin
                want_cpu = (c % 2) == 1;
                total++;
                if (cpu_ack !== want_cpu || tone_ack !== !want_cpu) begin
                    bad++;
                    $display("FAIL alt_ack c=%0d got=%b%b want=%b%b", c, cpu_ack, tone_ack, want_cpu, !want_cpu);
                end
            end else begin
                total++;
                if (cpu_ack !== 1'b0 || tone_ack !== 1'b0) begin bad++; $display("FAIL alt_tail_ack c=%0d got=%b%b want=00", c, cpu_ack, tone_ack); end
            end
            if (cpu_ack) cpu_exp.push_back(8'hA5);
            if (tone_ack) begin
                tone_exp.push_back(8'hA5);
                if (c - last_tone > max_gap) max_gap = c - last_tone;
                last_tone = c;
            end
        end
        total++; if (max_gap != 2) begin bad++; $display("FAIL alt_gap got=%0d want=2", max_gap); end
        total++; if (cpu_exp.size() != 0 || tone_exp.size() != 0) begin bad++; $display("FAIL alt_drain got=%0d/%0d want=0/0", cpu_exp.size(), tone_exp.size()); end
    endtask

    task automatic test_tone_read;
        int lat;
        cpu_xfer(1'b1, 3'd1, 5'd0, 8'h3C, lat);
        total++; if (lat != 1) begin bad++; $display("FAIL wr13c_lat got=%0d want=1", lat); end
        tone_exp.push_back(8'h3C);
        tone_xfer(3'd1, 5'd0, lat);
        total++; if (lat != 1) begin bad++; $display("FAIL tone_lat got=%0d want=1", lat); end
        @(posedge clk); #1;
        total++; if (tone_q_valid !== 1'b1 || tone_q !== tone_exp.pop_front()) begin bad++; $display("FAIL tone_rd got=%b/%h want=1/3c", tone_q_valid, tone_q); end
        total++; if (cpu_q_valid !== 1'b0 || cpu_q !== 8'hA5) begin bad++; $display("FAIL tone_cpu_side got=%b/%h want=0/a5", cpu_q_valid, cpu_q); end
    endtask

    task automatic test_clear_restart;
        int n, early;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (100) @(posedge clk);
        @(negedge clk);
        clear_req = 1'b1;
        @(posedge clk); #1;
        clear_req = 1'b0;
        n = busy ? 1 : 0;
        early = 0;
        cpu_we = 1'b1; cpu_ch = 3'd3; cpu_a = 5'd3; cpu_d = 8'h77; cpu_req = 1'b1;
        tone_ch = 3'd3; tone_a = 5'd3; tone_req = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (!busy) break;
            n++;
            if (cpu_ack || tone_ack) early++;
        end
        total++; if (n != 256) begin bad++; $display("FAIL restart_len got=%0d want=256", n); end
        total++; if (early != 0) begin bad++; $display("FAIL restart_early_ack got=%0d want=0", early); end
        @(posedge clk); #1;
        total++; if (cpu_ack !== 1'b1 || tone_ack !== 1'b0) begin bad++; $display("FAIL restart_first got=%b%b want=10", cpu_ack, tone_ack); end
        cpu_req = 1'b0;
        tone_exp.push_back(8'h77);
        @(posedge clk); #1;
        total++; if (tone_ack !== 1'b1 || cpu_ack !== 1'b0) begin bad++; $display("FAIL restart_second got=%b%b want=01", cpu_ack, tone_ack); end
        tone_req = 1'b0;
        @(posedge clk); #1;
        total++; if (tone_q_valid !== 1'b1 || tone_q !== tone_exp.pop_front()) begin bad++; $display("FAIL restart_raw got=%b/%h want=1/77", tone_q_valid, tone_q); end
    endtask

    task automatic test_reset_mid_read;
        int lat, seen;
        seen = 0;
        tone_xfer(3'd3, 5'd3, lat);
        reset = 1'b1;
        total++; if (lat != 1) begin bad++; $display("FAIL mid_lat got=%0d want=1", lat); end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (tone_q_valid) seen++;
        end
        total++; if (tone_q !== 8'h00) begin bad++; $display("FAIL mid_tone_q got=%h want=00", tone_q); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b want=1", busy); end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (tone_q_valid) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL mid_valid got=%0d want=0", seen); end
    endtask

    initial begin
        reset = 1'b1; clear_req = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_ch = '0; cpu_a = '0; cpu_d = '0;
        tone_req = 1'b0; tone_ch = '0; tone_a = '0;
        test_reset;
        test_clear_reads;
        test_write_read;
        test_back_to_back;
        test_tone_read;
        test_clear_restart;
        test_reset_mid_read;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wts_wave_ram.md
Name: wts_wave_ram

Overview:
Parametrised wave-table sample memory shared by the CPU register interface and the tone generator. It holds CH_NUM banks of 2**ADDR_W samples each. A single-port array is arbitrated between three sources: an internal clear sequencer, CPU read/write requests, and tone-generator read requests. It sits between the bus decoder and the per-channel tone engines in the sound core.

Parameters:
DATA_W, 8, sample width in bits
ADDR_W, 5, per-channel sample address width (32 samples/channel)
CH_W, 3, channel-select width; CH_NUM = 2**CH_W banks (8)
CLEAR_VAL, 0, value written to every word by the clear sequencer

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
clear_req  input  1  single-cycle pulse; restarts the full-memory clear
busy  output  1  high while the clear sequencer owns the array
cpu_req  input  1  CPU access request; held until cpu_ack
cpu_we  input  1  1 = write, 0 = read; stable while cpu_req is high
cpu_ch  input  CH_W  CPU channel select
cpu_a  input  ADDR_W  CPU sample address
cpu_d  input  DATA_W  CPU write data
cpu_ack  output  1  one-cycle grant pulse
cpu_q  output  DATA_W  CPU read data; holds its value between reads
cpu_q_valid  output  1  one-cycle pulse, cpu_q updated
tone_req  input  1  tone read request; held until tone_ack
tone_ch  input  CH_W  tone channel select
tone_a  input  ADDR_W  tone sample address
tone_ack  output  1  one-cycle grant pulse
tone_q  output  DATA_W  tone read data; holds its value between reads
tone_q_valid  output  1  one-cycle pulse, tone_q updated

Behaviour:
- Array: CH_NUM*2**ADDR_W words, DATA_W bits wide. Physical address = {ch, a}. There is exactly one access per clk.
- Reset (asynchronous, active-high) values:
  - busy=1, state=ST_CLEAR, clear counter=0.
  - All acks and valids = 0; cpu_q = 0; tone_q = 0; fairness flag = 0.
  - Array contents are not reset; the clear sequencer initialises them.
- FSM states:
  - ST_CLEAR: writes CLEAR_VAL at the counter address each cycle and increments the counter. On the cycle that writes the last address (all ones), the next state is ST_IDLE and busy drops the following cycle. Duration = CH_NUM*2**ADDR_W cycles (256 at defaults). No acks are issued during ST_CLEAR; pending requests stay pending.
  - ST_IDLE: arbitrates CPU and tone requests.
- clear_req in either state: counter goes to 0, state to ST_CLEAR, busy=1 next cycle. A clear_req arriving mid-clear restarts the clear from address 0. A clear_req has priority over any grant in the same cycle (no ack is issued that cycle).
- Arbitration in ST_IDLE, evaluated each cycle on the sampled request inputs:
  - Only cpu_req: grant CPU.
  - Only tone_req: grant tone.
  - Both: grant CPU, unless the fairness flag is set, in which case grant tone.
  - Fairness flag: set when the CPU is granted while tone_req is high; cleared on any tone grant.
  - Result: the tone generator waits at most one cycle under continuous CPU traffic.
- Grant cycle N:
  - The ack pulses high in cycle N+1 (registered). The requester may drop req in cycle N+1.
  - The arbiter must not re-grant the same source in cycle N+1: a req still high in the ack cycle is ignored for that cycle.
- Write: the array is updated at the grant edge. cpu_q and cpu_q_valid are unaffected.
- Read latency:
  - Array read is registered at the grant edge (cycle N).
  - q is updated and q_valid pulses in cycle N+2, one cycle after the ack.
- Read-after-write to the same address on consecutive grants returns the new data. There is no read-during-write hazard because there is one access per cycle.
- Reset asserted mid-read: the pending valid is discarded.

Decomposition:
- Package wts_wave_ram_pkg holds:
  - the state encoding (ST_CLEAR, ST_IDLE);
  - the grant-select encoding (GNT_NONE, GNT_CLR, GNT_CPU, GNT_TONE);
  - a function computing total depth from ADDR_W and CH_W.
- Natural sub-module: wts_ram_sp, a parametrised single-port DATA_W x DEPTH synchronous array (registered read, write-enable), with no reset.
- The arbiter, FSM and output registers live in wts_wave_ram.

Test Plan:
- Release reset, no requests -> busy=1 for exactly 256 cycles then 0. CPU reads of ch7/a31 and ch0/a0 both return 0x00.
- After clear: CPU write ch2/a5 = 0xA5, then CPU read ch2/a5 -> cpu_ack the cycle after each grant. cpu_q=0xA5 with cpu_q_valid one cycle after the read ack.
- cpu_req and tone_req held continuously -> grants alternate CPU, tone, CPU, tone. tone_ack never more than 2 cycles apart.
- Write ch1/a0=0x3C, then tone read ch1/a0 -> tone_q=0x3C, tone_q_valid pulse. cpu_q and cpu_q_valid unchanged.
- clear_req at cycle 100 of the initial clear -> busy stays high 256 more cycles. Requests issued meanwhile get no ack until busy=0, then are served in arbiter order.
- Assert reset during a pending tone read -> tone_q_valid never pulses. tone_q=0 and busy=1 after reset.
